layer_scan_engine: RTL and testbench

Parametrised successor to the fixed 8-layer mask/frame-buffer path in the cube top level. It time-multiplexes an N-layer cube:
- blanks the anode drivers;
- streams one layer's pixels from the frame-buffer BRAM to the TLC update engine over a valid/ready handshake;
- waits for the TLC latch acknowledge;
- lights that layer for a programmed dwell time, then advances.

Adds double-buffer frame selection, a frame-sync pulse and anti-ghost blanking, none of which the current design has.

---
 rtl/layer_scan_engine.sv | 162 ++++++++++++++++
 tb/tb_layer_scan_engine.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_scan_engine.sv
// layer_scan_engine: time-multiplexed layer scan for an N-layer LED cube.
// Blank, stream one layer to the TLC engine, await its latch, then light it.
module layer_scan_engine #(
    parameter int LAYERS         = 8,
    parameter int LEDS_PER_LAYER = 64,
    parameter int DATA_W         = 8,
    parameter int ADDR_W         = 9,
    parameter int BLANK_CYCLES   = 100,
    parameter int DWELL_CYCLES   = 50000
) (
    input  logic                       io_clock,
    input  logic                       io_reset,
    input  logic                       io_enable,
    input  logic [ADDR_W-1:0]          io_frame_base,
    output logic [ADDR_W-1:0]          io_ram_read_address,
    input  logic [DATA_W-1:0]          io_ram_read_data,
    output logic                       io_pix_valid,
    input  logic                       io_pix_ready,
    output logic [DATA_W-1:0]          io_pix_data,
    output logic                       io_pix_last,
    output logic [$clog2(LAYERS)-1:0]  io_pix_layer,
    input  logic                       io_latch_done,
    output logic [LAYERS-1:0]          io_layer_mask,
    output logic                       io_frame_sync,
    output logic                       io_busy
);

    localparam int LW  = $clog2(LAYERS);
    localparam int IW  = $clog2(LEDS_PER_LAYER + 1);
    localparam int BW  = $clog2(BLANK_CYCLES + 1);
    localparam int DWW = $clog2(DWELL_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BLANK,
        S_FETCH,
        S_WAIT_LATCH,
        S_SHOW
    } state_t;

    state_t state, state_next;

    logic [ADDR_W-1:0] base_q;
    logic [LW-1:0]     layer;
    logic [IW-1:0]     idx;
    logic [BW-1:0]     blank_cnt;
    logic [DWW-1:0]    dwell_cnt;
    logic              pix_valid;
    logic              pix_last;
    logic [LW-1:0]     pix_layer;
    logic              fresh;
    logic [DATA_W-1:0] data_q;
    logic              frame_sync;

    logic blank_done;
    logic dwell_done;
    logic accept;
    logic issue;
    logic last_layer;
    logic frame_start;

    assign blank_done  = (blank_cnt == '0);
    assign dwell_done  = (dwell_cnt == '0);
    assign accept      = pix_valid && io_pix_ready;
    assign last_layer  = (layer == LW'(LAYERS - 1));
    assign issue       = (state == S_FETCH)
                      && (idx < IW'(LEDS_PER_LAYER))
                      && (!pix_valid || io_pix_ready);
    assign frame_start = io_enable
                      && ((state == S_IDLE)
                      || (state == S_SHOW && dwell_done && last_layer));

    always_ff @(posedge io_clock) begin
        if (io_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:       if (io_enable) state_next = S_BLANK;
            S_BLANK:      if (blank_done) state_next = S_FETCH;
            S_FETCH:      if (accept && pix_last) state_next = S_WAIT_LATCH;
            S_WAIT_LATCH: if (io_latch_done) state_next = S_SHOW;
            S_SHOW:       if (dwell_done) state_next = io_enable ? S_BLANK : S_IDLE;
            default:      state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge io_clock) begin
        if (io_reset) begin
            base_q     <= '0;
            layer      <= '0;
            idx        <= '0;
            blank_cnt  <= BW'(BLANK_CYCLES - 1);
            dwell_cnt  <= DWW'(DWELL_CYCLES - 1);
            pix_valid  <= 1'b0;
            pix_last   <= 1'b0;
            pix_layer  <= '0;
            fresh      <= 1'b0;
            data_q     <= '0;
            frame_sync <= 1'b0;
        end else begin
            frame_sync <= frame_start;
            if (frame_start) begin
                base_q <= io_frame_base;
                layer  <= '0;
            end else if (state == S_SHOW && dwell_done && !last_layer) begin
                layer <= layer + 1'b1;
            end
            // Counters reload whenever their state is not active.
            if (state != S_BLANK) begin
                blank_cnt <= BW'(BLANK_CYCLES - 1);
            end else if (!blank_done) begin
                blank_cnt <= blank_cnt - 1'b1;
            end
            if (state != S_SHOW) begin
                dwell_cnt <= DWW'(DWELL_CYCLES - 1);
            end else if (!dwell_done) begin
                dwell_cnt <= dwell_cnt - 1'b1;
            end
            if (state != S_FETCH) begin
                idx <= '0;
            end else if (issue) begin
                idx <= idx + 1'b1;
            end
            // BRAM output is used directly the cycle it arrives, then held.
            fresh <= issue;
            if (fresh) begin
                data_q <= io_ram_read_data;
            end
            if (issue) begin
                pix_valid <= 1'b1;
                pix_last  <= (idx == IW'(LEDS_PER_LAYER - 1));
                pix_layer <= layer;
            end else if (accept) begin
                pix_valid <= 1'b0;
                pix_last  <= 1'b0;
            end
        end
    end

    always_comb begin
        io_layer_mask       = '0;
        io_busy             = (state != S_IDLE);
        io_pix_valid        = pix_valid;
        io_pix_last         = pix_last;
        io_pix_layer        = pix_layer;
        io_pix_data         = fresh ? io_ram_read_data : data_q;
        io_frame_sync       = frame_sync;
        io_ram_read_address = base_q
                            + ADDR_W'(layer) * ADDR_W'(LEDS_PER_LAYER)
                            + ADDR_W'(idx);
        if (state == S_SHOW) begin
            io_layer_mask = LAYERS'(1) << layer;
        end
    end

endmodule

// File: tb/tb_layer_scan_engine.sv
// Directed bench for layer_scan_engine: a 4-layer instance and a minimal
// 2-layer instance, both fed by a BRAM model returning data = address.
module tb_layer_scan_engine;

    localparam int AW = 9;
    localparam int DW = 9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_a   = 1'b1;
    logic          en_a    = 1'b0;
    logic          ready_a = 1'b1;
    logic          latch_a = 1'b0;
    logic [AW-1:0] base_a  = '0;
    logic [AW-1:0] addr_a;
    logic [DW-1:0] rdata_a = '0;
    logic [DW-1:0] pdata_a;
    logic          pvalid_a, plast_a, sync_a, busy_a;
    logic [1:0]    player_a;
    logic [3:0]    mask_a;

    logic          rst_b   = 1'b1;
    logic          en_b    = 1'b0;
    logic          ready_b = 1'b1;
    logic          latch_b = 1'b0;
    logic [AW-1:0] base_b  = '0;
    logic [AW-1:0] addr_b;
    logic [DW-1:0] rdata_b = '0;
    logic [DW-1:0] pdata_b;
    logic          pvalid_b, plast_b, sync_b, busy_b;
    logic [0:0]    player_b;
    logic [1:0]    mask_b;

    always @(posedge clk) rdata_a <= addr_a;
    always @(posedge clk) rdata_b <= addr_b;

    layer_scan_engine #(
        .LAYERS(4), .LEDS_PER_LAYER(4), .DATA_W(DW), .ADDR_W(AW),
        .BLANK_CYCLES(2), .DWELL_CYCLES(5)
    ) dut_a (
        .io_clock(clk), .io_reset(rst_a), .io_enable(en_a),
        .io_frame_base(base_a), .io_ram_read_address(addr_a),
        .io_ram_read_data(rdata_a), .io_pix_valid(pvalid_a),
        .io_pix_ready(ready_a), .io_pix_data(pdata_a),
        .io_pix_last(plast_a), .io_pix_layer(player_a),
        .io_latch_done(latch_a), .io_layer_mask(mask_a),
        .io_frame_sync(sync_a), .io_busy(busy_a)
    );

    layer_scan_engine #(
        .LAYERS(2), .LEDS_PER_LAYER(1), .DATA_W(DW), .ADDR_W(AW),
        .BLANK_CYCLES(1), .DWELL_CYCLES(1)
    ) dut_b (
        .io_clock(clk), .io_reset(rst_b), .io_enable(en_b),
        .io_frame_base(base_b), .io_ram_read_address(addr_b),
        .io_ram_read_data(rdata_b), .io_pix_valid(pvalid_b),
        .io_pix_ready(ready_b), .io_pix_data(pdata_b),
        .io_pix_last(plast_b), .io_pix_layer(player_b),
        .io_latch_done(latch_b), .io_layer_mask(mask_b),
        .io_frame_sync(sync_b), .io_busy(busy_b)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    bit auto_a = 1'b1;
    bit auto_b = 1'b1;
    bit bp     = 1'b0;
    bit pend_a = 1'b0;
    bit pend_b = 1'b0;

    logic [DW-1:0] acc_a[$];
    bit            lastq_a[$];
    logic [1:0]    layq_a[$];
    logic [3:0]    maskq_a[$];
    int            syncq_a[$];
    logic [DW-1:0] acc_b[$];
    bit            lastq_b[$];
    int            syncq_b[$];
    int            onq_b[$];
    logic [1:0]    prev_mask_b = '0;

    bit            stalled  = 1'b0;
    logic [DW-1:0] st_data  = '0;
    bit            st_last  = 1'b0;
    logic [1:0]    st_layer = '0;
    int            stall_err = 0;
    int            hot_err   = 0;

    // One clock of stimulus and observation; inputs change on the falling edge.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (bp) ready_a = (cyc % 4 == 0) || (cyc % 4 == 3);
        if (stalled && (pvalid_a !== 1'b1 || pdata_a !== st_data
            || plast_a !== st_last || player_a !== st_layer))
            stall_err++;
        stalled  = pvalid_a && !ready_a;
        st_data  = pdata_a;
        st_last  = plast_a;
        st_layer = player_a;
        if (pvalid_a && ready_a) begin
            acc_a.push_back(pdata_a);
            lastq_a.push_back(plast_a);
            layq_a.push_back(player_a);
        end
        maskq_a.push_back(mask_a);
        if (!$onehot0(mask_a)) hot_err++;
        if (!$onehot0(mask_b)) hot_err++;
        if (sync_a) syncq_a.push_back(cyc);
        latch_a = pend_a;
        pend_a  = auto_a && pvalid_a && ready_a && plast_a;
        if (pvalid_b && ready_b) begin
            acc_b.push_back(pdata_b);
            lastq_b.push_back(plast_b);
        end
        if (sync_b) syncq_b.push_back(cyc);
        if (mask_b != 0 && prev_mask_b == 0) onq_b.push_back(cyc);
        prev_mask_b = mask_b;
        latch_b = pend_b;
        pend_b  = auto_b && pvalid_b && ready_b && plast_b;
    endtask

    task automatic clear_logs();
        acc_a.delete(); lastq_a.delete(); layq_a.delete();
        maskq_a.delete(); syncq_a.delete();
        acc_b.delete(); lastq_b.delete(); syncq_b.delete(); onq_b.delete();
        stall_err = 0;
    endtask

    task automatic drain(output bit ok);
        int n;
        n = 0;
        en_a = 1'b0;
        while (busy_a && n < 300) begin
            step();
            n++;
        end
        ok = !busy_a;
    endtask

    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1;
        repeat (3) step();
        rst_a = 1'b0; rst_b = 1'b0;
        step();
        total++; if (mask_a !== 4'b0) begin bad++; $display("FAIL rst_mask got=%b want=0000", mask_a); end
        total++; if (pvalid_a !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", pvalid_a); end
        total++; if (plast_a !== 1'b0) begin bad++; $display("FAIL rst_last got=%b want=0", plast_a); end
        total++; if (pdata_a !== '0) begin bad++; $display("FAIL rst_data got=%0d want=0", pdata_a); end
        total++; if (player_a !== 2'd0) begin bad++; $display("FAIL rst_layer got=%0d want=0", player_a); end
        total++; if (addr_a !== '0) begin bad++; $display("FAIL rst_addr got=%0d want=0", addr_a); end
        total++; if (sync_a !== 1'b0) begin bad++; $display("FAIL rst_sync got=%b want=0", sync_a); end
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy_a); end
        total++; if (mask_b !== 2'b0 || busy_b !== 1'b0) begin
            bad++; $display("FAIL rst_b got mask=%b busy=%b want 00/0", mask_b, busy_b);
        end
    endtask

    task automatic test_basic();
        int n;
        int rv[$];
        int rl[$];
        int cur;
        int len;
        bit ok;
        clear_logs();
        base_a = 0; ready_a = 1'b1; auto_a = 1'b1; bp = 1'b0; en_a = 1'b1;
        n = 0;
        while (acc_a.size() < 16 && n < 200) begin step(); n++; end
        repeat (20) step();
        total++; if (acc_a.size() < 16) begin
            bad++; $display("FAIL basic_count got=%0d want>=16", acc_a.size());
        end
        for (int i = 0; i < 16 && i < acc_a.size(); i++) begin
            total++;
            if (acc_a[i] !== DW'(i) || lastq_a[i] !== (i % 4 == 3) || layq_a[i] !== 2'(i / 4)) begin
                bad++;
                $display("FAIL basic_pix%0d got d=%0d l=%b y=%0d want d=%0d l=%b y=%0d",
                         i, acc_a[i], lastq_a[i], layq_a[i], i, (i % 4 == 3), i / 4);
            end
        end
        cur = 0; len = 0;
        foreach (maskq_a[i]) begin
            if (int'(maskq_a[i]) == cur && cur != 0) begin
                len++;
            end else begin
                if (cur != 0) begin rv.push_back(cur); rl.push_back(len); end
                cur = int'(maskq_a[i]); len = 1;
            end
        end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (rv.size() <= k) begin
                bad++; $display("FAIL basic_mask%0d got=none want=%0d x5", k, 1 << k);
            end else if (rv[k] != (1 << k) || rl[k] != 5) begin
                bad++; $display("FAIL basic_mask%0d got=%0d x%0d want=%0d x5", k, rv[k], rl[k], 1 << k);
            end
        end
        total++;
        if (syncq_a.size() < 2) begin
            bad++; $display("FAIL basic_sync got=%0d pulses want>=2", syncq_a.size());
        end else if (syncq_a[1] - syncq_a[0] != 52) begin
            bad++; $display("FAIL basic_sync period got=%0d want=52", syncq_a[1] - syncq_a[0]);
        end
        drain(ok);
        total++; if (!ok) begin bad++; $display("FAIL basic_drain got=busy want=idle"); end
    endtask

    task automatic test_backpressure();
        int n;
        bit ok;
        clear_logs();
        base_a = 0; bp = 1'b1; en_a = 1'b1;
        n = 0;
        while (acc_a.size() < 16 && n < 600) begin step(); n++; end
        total++; if (acc_a.size() != 16) begin
            bad++; $display("FAIL bp_count got=%0d want=16", acc_a.size());
        end
        for (int i = 0; i < acc_a.size() && i < 16; i++) begin
            total++;
            if (acc_a[i] !== DW'(i) || lastq_a[i] !== (i % 4 == 3)) begin
                bad++; $display("FAIL bp_pix%0d got d=%0d l=%b want d=%0d l=%b",
                                i, acc_a[i], lastq_a[i], i, (i % 4 == 3));
            end
        end
        total++; if (stall_err != 0) begin
            bad++; $display("FAIL bp_stable got=%0d changes want=0", stall_err);
        end
        bp = 1'b0; ready_a = 1'b1;
        drain(ok);
        total++; if (!ok) begin bad++; $display("FAIL bp_drain got=busy want=idle"); end
    endtask

    task automatic test_double_buffer();
        int n;
        int exp_v;
        bit ok;
        clear_logs();
        base_a = 9'd500; en_a = 1'b1;
        n = 0;
        while (acc_a.size() < 20 && n < 400) begin
            if (acc_a.size() >= 4) base_a = 9'd100;
            step();
            n++;
        end
        total++; if (acc_a.size() < 20) begin
            bad++; $display("FAIL dbuf_count got=%0d want=20", acc_a.size());
        end
        for (int i = 0; i < 20 && i < acc_a.size(); i++) begin
            exp_v = (i < 16) ? (500 + i) % 512 : 100 + (i - 16);
            total++;
            if (acc_a[i] !== DW'(exp_v)) begin
                bad++; $display("FAIL dbuf_pix%0d got=%0d want=%0d", i, acc_a[i], exp_v);
            end
        end
        drain(ok);
        base_a = '0;
        total++; if (!ok) begin bad++; $display("FAIL dbuf_drain got=busy want=idle"); end
    endtask

    task automatic test_latch_gating();
        int lit;
        bit ok;
        clear_logs();
        auto_a = 1'b0; en_a = 1'b1;
        for (int i = 1; i <= 47; i++) begin
            step();
            latch_a = (i <= 7) && (i % 2 == 1);
        end
        lit = 0;
        foreach (maskq_a[i]) if (maskq_a[i] != 0) lit++;
        total++; if (lit != 0) begin bad++; $display("FAIL gate_mask got=%0d lit want=0", lit); end
        total++; if (acc_a.size() != 4) begin
            bad++; $display("FAIL gate_fetch got=%0d pix want=4", acc_a.size());
        end
        en_a = 1'b0;
        step();
        latch_a = 1'b1;
        step();
        latch_a = 1'b0;
        total++; if (mask_a !== 4'b0001) begin
            bad++; $display("FAIL gate_show got=%b want=0001", mask_a);
        end
        auto_a = 1'b1;
        drain(ok);
        total++; if (!ok) begin bad++; $display("FAIL gate_drain got=busy want=idle"); end
    endtask

    task automatic test_disable();
        int n;
        int c1;
        int c2;
        int c4;
        clear_logs();
        en_a = 1'b1;
        n = 0;
        while (!(pvalid_a && player_a == 2'd1) && n < 100) begin step(); n++; end
        total++; if (!(pvalid_a && player_a == 2'd1)) begin
            bad++; $display("FAIL dis_reach got layer=%0d want=1", player_a);
        end
        en_a = 1'b0;
        n = 0;
        while (busy_a && n < 200) begin step(); n++; end
        c1 = 0; c2 = 0; c4 = 0;
        foreach (maskq_a[i]) begin
            if (maskq_a[i] == 4'b0001) c1++;
            if (maskq_a[i] == 4'b0010) c2++;
            if (maskq_a[i] == 4'b0100) c4++;
        end
        total++; if (c1 != 5 || c2 != 5 || c4 != 0) begin
            bad++; $display("FAIL dis_show got=%0d/%0d/%0d want=5/5/0", c1, c2, c4);
        end
        total++; if (busy_a !== 1'b0 || mask_a !== 4'b0) begin
            bad++; $display("FAIL dis_idle got busy=%b mask=%b want 0/0000", busy_a, mask_a);
        end
        repeat (10) step();
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL dis_stay got=%b want=0", busy_a); end
    endtask

    task automatic test_reset_midrun();
        int n;
        clear_logs();
        en_a = 1'b1;
        n = 0;
        while (mask_a == 4'b0 && n < 100) begin step(); n++; end
        total++; if (mask_a == 4'b0) begin bad++; $display("FAIL rshow_reach got=0000 want=lit"); end
        rst_a = 1'b1;
        step();
        total++; if (mask_a !== 4'b0 || pvalid_a !== 1'b0 || busy_a !== 1'b0) begin
            bad++; $display("FAIL rshow got mask=%b v=%b busy=%b want 0000/0/0", mask_a, pvalid_a, busy_a);
        end
        en_a = 1'b0; rst_a = 1'b0;
        step();
        ready_a = 1'b0; en_a = 1'b1;
        n = 0;
        while (!pvalid_a && n < 100) begin step(); n++; end
        total++; if (!pvalid_a) begin bad++; $display("FAIL rpix_reach got=0 want=1"); end
        rst_a = 1'b1;
        step();
        total++; if (pvalid_a !== 1'b0 || pdata_a !== '0 || addr_a !== '0) begin
            bad++; $display("FAIL rpix got v=%b d=%0d a=%0d want 0/0/0", pvalid_a, pdata_a, addr_a);
        end
        en_a = 1'b0; rst_a = 1'b0; ready_a = 1'b1;
        step();
    endtask

    task automatic test_sweep();
        clear_logs();
        en_b = 1'b1;
        repeat (25) step();
        en_b = 1'b0;
        total++; if (acc_b.size() < 4) begin
            bad++; $display("FAIL sweep_count got=%0d want>=4", acc_b.size());
        end
        for (int i = 0; i < 4 && i < acc_b.size(); i++) begin
            total++;
            if (acc_b[i] !== DW'(i % 2) || lastq_b[i] !== 1'b1) begin
                bad++; $display("FAIL sweep_pix%0d got d=%0d l=%b want d=%0d l=1",
                                i, acc_b[i], lastq_b[i], i % 2);
            end
        end
        for (int i = 1; i < 4; i++) begin
            total++;
            if (onq_b.size() <= i) begin
                bad++; $display("FAIL sweep_period%0d got=none want=5", i);
            end else if (onq_b[i] - onq_b[i-1] != 5) begin
                bad++; $display("FAIL sweep_period%0d got=%0d want=5", i, onq_b[i] - onq_b[i-1]);
            end
        end
        total++;
        if (syncq_b.size() < 2) begin
            bad++; $display("FAIL sweep_sync got=%0d pulses want>=2", syncq_b.size());
        end else if (syncq_b[1] - syncq_b[0] != 10) begin
            bad++; $display("FAIL sweep_sync got=%0d want=10", syncq_b[1] - syncq_b[0]);
        end
        repeat (10) step();
        total++; if (busy_b !== 1'b0) begin bad++; $display("FAIL sweep_idle got=%b want=0", busy_b); end
    endtask

    task automatic test_onehot();
        total++; if (hot_err != 0) begin
            bad++; $display("FAIL mask_onehot got=%0d bad cycles want=0", hot_err);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_double_buffer();
        test_latch_gating();
        test_disable();
        test_reset_midrun();
        test_sweep();
        test_onehot();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
